// File: rtl/riscv_hzd_pkg.sv
// Shared definitions for the decode->execute hazard controller:
// FSM state encoding, execute-unit select encoding and small decode helpers.
package riscv_hzd_pkg;

    typedef enum logic [1:0] {
        HZD_IDLE    = 2'b00,
        HZD_MD_WAIT = 2'b01,
        HZD_HALT    = 2'b10
    } hzd_state_e;

    typedef enum logic [1:0] {
        FUNC_ALU = 2'b00,
        FUNC_CSR = 2'b01,
        FUNC_MUL = 2'b10,
        FUNC_DIV = 2'b11
    } hzd_func_e;

    // True when the execute-stage instruction needs the multi-cycle mul/div unit.
    function automatic logic is_md_op(input logic [1:0] funcsel);
        return (funcsel == FUNC_MUL) || (funcsel == FUNC_DIV);
    endfunction

    // Load in execute whose destination (never x0) feeds a source of the decode instruction.
    function automatic logic is_load_use(input logic       memread,
                                         input logic [4:0] rd,
                                         input logic [4:0] rs1,
                                         input logic [4:0] rs2);
        return memread && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/riscv_hzd_md_wdog.sv
// Mul/div watchdog: counts cycles spent waiting on the mul/div unit.
// Clear has priority over increment; with neither asserted the count is frozen.
// expire is raised while the count sits at MD_TIMEOUT-1.
module riscv_hzd_md_wdog #(
    parameter int MD_TIMEOUT = 64
) (
    input  logic i_riscv_hzd_clk,
    input  logic i_riscv_hzd_rst_n,
    input  logic wdog_clr,
    input  logic wdog_inc,
    output logic wdog_expire
);

    localparam int                CNT_W    = $clog2(MD_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    logic [CNT_W-1:0] wdog_cnt;

    // Wait-cycle counter: clear on entry to the wait, advance while waiting, hold otherwise.
    always_ff @(posedge i_riscv_hzd_clk or negedge i_riscv_hzd_rst_n) begin
        if (!i_riscv_hzd_rst_n) begin
            wdog_cnt <= '0;
        end else if (wdog_clr) begin
            wdog_cnt <= '0;
        end else if (wdog_inc) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    assign wdog_expire = (wdog_cnt == CNT_LAST);

endmodule

// File: rtl/riscv_hzd_de_ctrl.sv
// Hazard / sequencing controller around the decode->execute pipeline register.
// Produces hold (stall) and bubble (flush) controls for PC, F/D, D/E and E/M,
// and sequences the multi-cycle mul/div unit (start, kill, watchdog timeout).
// Event priority each cycle: trap > mem_busy > mul/div sequencing > redirect > load-use.
// Optional build macro RISCV_HZD_PERF_EN adds a saturating count of D/E stall cycles;
// without it o_riscv_hzd_stall_cnt is tied to zero and no counter flops exist.
module riscv_hzd_de_ctrl
    import riscv_hzd_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int PERF_W     = 32
) (
    input  logic              i_riscv_hzd_clk,
    input  logic              i_riscv_hzd_rst_n,
    input  logic [4:0]        i_riscv_hzd_rs1addr_d,
    input  logic [4:0]        i_riscv_hzd_rs2addr_d,
    input  logic [4:0]        i_riscv_hzd_rdaddr_e,
    input  logic              i_riscv_hzd_memread_e,
    input  logic [1:0]        i_riscv_hzd_funcsel_e,
    input  logic              i_riscv_hzd_md_done,
    input  logic              i_riscv_hzd_redirect_e,
    input  logic              i_riscv_hzd_trap,
    input  logic              i_riscv_hzd_mem_busy,
    output logic              o_riscv_hzd_stall_pc,
    output logic              o_riscv_hzd_stall_fd,
    output logic              o_riscv_hzd_stall_de,
    output logic              o_riscv_hzd_stall_em,
    output logic              o_riscv_hzd_flush_fd,
    output logic              o_riscv_hzd_flush_de,
    output logic              o_riscv_hzd_flush_em,
    output logic              o_riscv_hzd_md_start,
    output logic              o_riscv_hzd_md_kill,
    output logic              o_riscv_hzd_md_timeout,
    output logic [PERF_W-1:0] o_riscv_hzd_stall_cnt
);

    hzd_state_e state;
    hzd_state_e nxt_state;

    logic stall_pc;
    logic stall_fd;
    logic stall_de;
    logic stall_em;
    logic flush_fd;
    logic flush_de;
    logic flush_em;
    logic md_start;
    logic md_kill;
    logic md_timeout;
    logic wdog_clr;
    logic wdog_inc;
    logic wdog_expire;
    logic load_use;

    assign load_use = is_load_use(i_riscv_hzd_memread_e, i_riscv_hzd_rdaddr_e,
                                  i_riscv_hzd_rs1addr_d, i_riscv_hzd_rs2addr_d);

    riscv_hzd_md_wdog #(
        .MD_TIMEOUT (MD_TIMEOUT)
    ) u_md_wdog (
        .i_riscv_hzd_clk   (i_riscv_hzd_clk),
        .i_riscv_hzd_rst_n (i_riscv_hzd_rst_n),
        .wdog_clr          (wdog_clr),
        .wdog_inc          (wdog_inc),
        .wdog_expire       (wdog_expire)
    );

    // Prioritised hazard resolution and next-state selection.
    always_comb begin
        stall_pc   = 1'b0;
        stall_fd   = 1'b0;
        stall_de   = 1'b0;
        stall_em   = 1'b0;
        flush_fd   = 1'b0;
        flush_de   = 1'b0;
        flush_em   = 1'b0;
        md_start   = 1'b0;
        md_kill    = 1'b0;
        md_timeout = 1'b0;
        wdog_clr   = 1'b0;
        wdog_inc   = 1'b0;
        nxt_state  = state;

        if (i_riscv_hzd_trap) begin
            // Trap redirect squashes everything younger, including an in-flight mul/div.
            flush_fd  = 1'b1;
            flush_de  = 1'b1;
            flush_em  = 1'b1;
            md_kill   = (state == HZD_MD_WAIT);
            wdog_clr  = 1'b1;
            nxt_state = HZD_IDLE;
        end else if (i_riscv_hzd_mem_busy) begin
            // Memory not ready: freeze the whole pipe, FSM and watchdog included.
            stall_pc = 1'b1;
            stall_fd = 1'b1;
            stall_de = 1'b1;
            stall_em = 1'b1;
        end else begin
            case (state)
                HZD_IDLE: begin
                    if (is_md_op(i_riscv_hzd_funcsel_e)) begin
                        // Launch mul/div; E/M gets bubbles until the result returns.
                        md_start  = 1'b1;
                        stall_pc  = 1'b1;
                        stall_fd  = 1'b1;
                        stall_de  = 1'b1;
                        flush_em  = 1'b1;
                        wdog_clr  = 1'b1;
                        nxt_state = HZD_MD_WAIT;
                    end else if (i_riscv_hzd_redirect_e) begin
                        // Wrong-path instructions in F/D and D/E are discarded;
                        // any load-use on them is moot.
                        flush_fd = 1'b1;
                        flush_de = 1'b1;
                    end else if (load_use) begin
                        // Hold fetch/decode one cycle and insert a bubble into execute.
                        stall_pc = 1'b1;
                        stall_fd = 1'b1;
                        flush_de = 1'b1;
                    end
                end
                HZD_MD_WAIT: begin
                    if (i_riscv_hzd_md_done) begin
                        // Result valid: let E/M capture it and D/E advance.
                        nxt_state = HZD_IDLE;
                    end else begin
                        stall_pc = 1'b1;
                        stall_fd = 1'b1;
                        stall_de = 1'b1;
                        flush_em = 1'b1;
                        if (wdog_expire) begin
                            md_timeout = 1'b1;
                            md_kill    = 1'b1;
                            nxt_state  = HZD_HALT;
                        end else begin
                            wdog_inc = 1'b1;
                        end
                    end
                end
                HZD_HALT: begin
                    // Hung mul/div: hold until the CSR unit takes a trap.
                    stall_pc = 1'b1;
                    stall_fd = 1'b1;
                    stall_de = 1'b1;
                    flush_em = 1'b1;
                end
                default: begin
                    nxt_state = HZD_IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge i_riscv_hzd_clk or negedge i_riscv_hzd_rst_n) begin
        if (!i_riscv_hzd_rst_n) begin
            state <= HZD_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Outputs are forced low during reset; a flush always overrides a stall on the same register.
    assign o_riscv_hzd_stall_pc   = i_riscv_hzd_rst_n & stall_pc;
    assign o_riscv_hzd_stall_fd   = i_riscv_hzd_rst_n & stall_fd & ~flush_fd;
    assign o_riscv_hzd_stall_de   = i_riscv_hzd_rst_n & stall_de & ~flush_de;
    assign o_riscv_hzd_stall_em   = i_riscv_hzd_rst_n & stall_em & ~flush_em;
    assign o_riscv_hzd_flush_fd   = i_riscv_hzd_rst_n & flush_fd;
    assign o_riscv_hzd_flush_de   = i_riscv_hzd_rst_n & flush_de;
    assign o_riscv_hzd_flush_em   = i_riscv_hzd_rst_n & flush_em;
    assign o_riscv_hzd_md_start   = i_riscv_hzd_rst_n & md_start;
    assign o_riscv_hzd_md_kill    = i_riscv_hzd_rst_n & md_kill;
    assign o_riscv_hzd_md_timeout = i_riscv_hzd_rst_n & md_timeout;

`ifdef RISCV_HZD_PERF_EN
    logic [PERF_W-1:0] stall_cnt;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] val);
        return (&val) ? val : val + 1'b1;
    endfunction

    // Saturating count of cycles in which the D/E register is held.
    always_ff @(posedge i_riscv_hzd_clk or negedge i_riscv_hzd_rst_n) begin
        if (!i_riscv_hzd_rst_n) begin
            stall_cnt <= '0;
        end else if (o_riscv_hzd_stall_de) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign o_riscv_hzd_stall_cnt = stall_cnt;
`else
    assign o_riscv_hzd_stall_cnt = '0;
`endif

endmodule
